// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and
// gates the decoder's write/branch requests into the final datapath strobes.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       go;
  logic       nz_en;
  logic       cv_en;

  // Conditions come in complementary pairs: cond[3:1] picks the base test
  // and cond[0] inverts it. 1111 is the one exception and never passes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = n ~^ v;
      3'b110:  base = ~z & (n ~^ v);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) begin
      return 1'b0;
    end
    return base ^ cond[0];
  endfunction

  assign Flags  = {nz_q, cv_q};
  assign CondEx = cond_eval(Cond, Flags);
  assign go     = CondEx & ~Stall & ~reset;

  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & ~NoWrite & go;
  assign MemWrite = MemW & go;

  assign nz_en = FlagW[1] & go;
  assign cv_en = FlagW[0] & go;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (nz_en) nz_d = ALUFlags[3:2];
    if (cv_en) cv_d = ALUFlags[1:0];
  end

  // Flag register stage: new flags become visible the cycle after the update.
  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= FLAG_RESET[3:2];
      cv_q <= FLAG_RESET[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Randomized and directed bench for cond_logic against a table-driven flag model.
module tb_cond_logic;

  localparam logic [3:0] FLAG_RESET = 4'b0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Stall;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;

  cond_logic #(.FLAG_RESET(FLAG_RESET)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Architectural meaning of each condition mnemonic.
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one instruction, check combinational outputs, then clock it in.
  task automatic step(input logic rst, input logic [3:0] cond, input logic [3:0] af,
                      input logic [1:0] fw, input logic pcs, input logic regw,
                      input logic memw, input logic nowr, input logic stall);
    logic pass, retire;
    reset = rst; Cond = cond; ALUFlags = af; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr; Stall = stall;
    #2;
    pass   = ref_cond(cond, mflags);
    retire = pass && !stall && !rst;
    check("Flags",    Flags,           mflags);
    check("CondEx",   {3'b0, CondEx},  {3'b0, pass});
    check("PCSrc",    {3'b0, PCSrc},   {3'b0, pcs && retire});
    check("RegWrite", {3'b0, RegWrite},{3'b0, regw && !nowr && retire});
    check("MemWrite", {3'b0, MemWrite},{3'b0, memw && retire});
    if (rst) mflags = FLAG_RESET;
    else if (retire) begin
      if (fw[1]) mflags[3:2] = af[3:2];
      if (fw[0]) mflags[1:0] = af[1:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    step(1'b0, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b1110; ALUFlags = 4'hF; FlagW = 2'b11;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0; Stall = 1'b0;
    @(posedge clk);
    #1;
    mflags = FLAG_RESET;
    check("rst_flags", Flags, 4'b0000);
    #2;
    check("rst_pcsrc_forced0", {3'b0, PCSrc}, 4'b0);
    check("rst_condex_live",   {3'b0, CondEx}, 4'b0001);
    step(1'b1, 4'b0001, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // AL register write
    step(1'b0, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // CMP-style then EQ branch
    step(1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("cmp_flags", Flags, 4'b0100);
    Cond = 4'b0000; PCS = 1'b1; Stall = 1'b0; FlagW = 2'b00; #1;
    check("beq_taken", {3'b0, PCSrc}, 4'b0001);
    step(1'b0, 4'b0000, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Partial NZ update keeps C,V
    load_flags(4'b1011);
    step(1'b0, 4'b1110, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("partial_nz", Flags, 4'b0111);

    // Failed condition blocks writes and its own flag update
    load_flags(4'b0000);
    step(1'b0, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("failed_cond_flags", Flags, 4'b0000);

    // Spot checks on signed compares
    load_flags(4'b1001);
    Cond = 4'b1010; FlagW = 2'b00; #1;
    check("ge_n1v1", {3'b0, CondEx}, 4'b0001);
    load_flags(4'b1000);
    Cond = 4'b1101; FlagW = 2'b00; #1;
    check("le_n1v0", {3'b0, CondEx}, 4'b0001);

    // Full sweep of flags x conditions
    for (int f = 0; f < 16; f++) begin
      load_flags(f[3:0]);
      for (int c = 0; c < 16; c++)
        step(1'b0, c[3:0], 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Stall holds flags and blocks strobes
    load_flags(4'b0110);
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b1110, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("stall_hold", Flags, 4'b0110);

    // Reset wins over a pending update
    step(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_wins", Flags, FLAG_RESET);

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 31) == 0, 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
